mult_datapath: RTL

Shift-and-add multiplier datapath that sits directly downstream of the multiplier CONTROL state machine. It consumes CONTROL's Load/Sh/Ad strobes and returns the two status bits CONTROL needs: M, the current multiplier LSB, and K, the final-shift flag. It holds the partial-product accumulator and the shift counter, and presents the 2N-bit product once CONTROL signals Done.

---
 rtl/mult_datapath.sv | 73 +++++++
 1 files changed

// File: rtl/mult_datapath.sv
// mult_datapath
// Shift-and-add multiplier datapath driven by the external CONTROL FSM.
// Holds the 2N+1-bit accumulator (carry, upper half, multiplier half) and
// the shift counter, and reports the current multiplier bit and the
// last-shift flag back to CONTROL.
//
// Ports:
//   Clk     - rising-edge clock shared with CONTROL
//   Rst_n   - asynchronous active-low reset, clears accumulator and counter
//   Mplier  - multiplier operand, captured on Load
//   Mcand   - multiplicand, held stable by the user for the whole operation
//   Load    - initialise accumulator with Mplier, clear counter
//   Sh      - shift accumulator right by one, advance counter
//   Ad      - add Mcand into the upper accumulator half (fuses with Sh)
//   M       - accumulator bit 0 (current multiplier bit)
//   K       - high when the next shift is the final one
//   Product - low 2N bits of the accumulator
module mult_datapath #(
  parameter int N = 4
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic [N-1:0]   Mplier,
  input  logic [N-1:0]   Mcand,
  input  logic           Load,
  input  logic           Sh,
  input  logic           Ad,
  output logic           M,
  output logic           K,
  output logic [2*N-1:0] Product
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [2*N:0]  acc;
  logic [CW-1:0] cnt;
  logic [N:0]    sum_upper;
  logic [2*N:0]  acc_added;
  logic [CW-1:0] cnt_next;

  // The add drops the old carry bit: the sum is always formed from the
  // N-bit upper half, and its own carry lands in the top accumulator bit.
  assign sum_upper = {1'b0, acc[2*N-1:N]} + {1'b0, Mcand};
  assign acc_added = {sum_upper, acc[N-1:0]};

  // Explicit wrap keeps the counter modulo N even when N is not a power
  // of two.
  assign cnt_next = (cnt == CW'(N - 1)) ? '0 : cnt + CW'(1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (Load) begin
      acc <= {{(N + 1){1'b0}}, Mplier};
      cnt <= '0;
    end else if (Ad && !Sh) begin
      acc <= acc_added;
    end else if (Sh && !Ad) begin
      acc <= {1'b0, acc[2*N:1]};
      cnt <= cnt_next;
    end else if (Sh && Ad) begin
      // Fused step: shift the freshly added value in the same edge.
      acc <= {1'b0, acc_added[2*N:1]};
      cnt <= cnt_next;
    end
  end

  assign M       = acc[0];
  assign K       = (cnt == CW'(N - 1));
  assign Product = acc[2*N-1:0];

endmodule
